// File: rtl/score_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : score_display_ctrl
// Brief    : Drives DIGITS 7-seg displays with a dash, a stored user high score
//            (browsed by button) or the live game score.
//            Optional macro SCORE_AUTO_CYCLE_EN adds timed auto-advance in BROWSE.
// Revision : 1.0 - initial release
// ============================================================================
module score_display_ctrl #(
  parameter int NUM_USERS   = 6,
  parameter int DIGITS      = 2,
  parameter int CYCLE_TICKS = 50000000
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              ac_button,
  input  logic                              access_granted,
  input  logic                              scoreRst,
  input  logic [4*DIGITS-1:0]               currentGameScore,
  input  logic [NUM_USERS*4*DIGITS-1:0]     score_bus,
  output logic [7*DIGITS-1:0]               hex_out,
  output logic [$clog2(NUM_USERS)-1:0]      sel_user
);

  localparam int C_SCORE_W = 4 * DIGITS;
  localparam int C_SEL_W   = $clog2(NUM_USERS);
  localparam logic [C_SEL_W-1:0] C_LAST_USER = C_SEL_W'(NUM_USERS - 1);
  localparam logic [6:0] C_DASH  = 7'b0111111;
  localparam logic [6:0] C_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    MODE_NOACCESS = 2'd0,
    MODE_BROWSE   = 2'd1,
    MODE_PLAY     = 2'd2
  } mode_t;

  // Active-low glyphs, bit 6 = g ... bit 0 = a.
  function automatic logic [6:0] seg_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  mode_t                 mode;
  logic                  btn_q, btn_d;
  logic                  btn_edge;
  logic                  advance;
  logic [C_SEL_W-1:0]    sel_q, sel_d;
  logic [7*DIGITS-1:0]   hex_q, hex_d;
  logic [C_SCORE_W-1:0]  user_score;

`ifdef SCORE_AUTO_CYCLE_EN
  localparam int C_CNT_W = $clog2(CYCLE_TICKS);
  localparam logic [C_CNT_W-1:0] C_LAST_TICK = C_CNT_W'(CYCLE_TICKS - 1);
  logic [C_CNT_W-1:0]    cnt_q, cnt_d;
  logic                  tick;
`endif

  always_comb begin
    mode = MODE_NOACCESS;
    if (access_granted) begin
      mode = scoreRst ? MODE_BROWSE : MODE_PLAY;
    end
  end

  // Score of the currently selected user; indices past NUM_USERS-1 cannot occur.
  always_comb begin
    user_score = '0;
    for (int k = 0; k < NUM_USERS; k++) begin
      if (sel_q == C_SEL_W'(k)) begin
        user_score = score_bus[k*C_SCORE_W +: C_SCORE_W];
      end
    end
  end

  // Button history tracks the input in every mode, so a button already held
  // when BROWSE is entered produces no edge.
  always_comb begin
    btn_d    = ac_button;
    btn_edge = ac_button & ~btn_q;
    advance  = 1'b0;
    sel_d    = '0;
`ifdef SCORE_AUTO_CYCLE_EN
    tick     = 1'b0;
    cnt_d    = '0;
`endif
    if (mode == MODE_BROWSE) begin
      sel_d = sel_q;
`ifdef SCORE_AUTO_CYCLE_EN
      tick    = (cnt_q == C_LAST_TICK);
      advance = btn_edge | tick;
      cnt_d   = advance ? '0 : cnt_q + C_CNT_W'(1);
`else
      advance = btn_edge;
`endif
      if (advance) begin
        sel_d = (sel_q == C_LAST_USER) ? '0 : sel_q + C_SEL_W'(1);
      end
    end
  end

  // Display content is built from the registered selection, giving the
  // one-cycle glyph latency after sel_user or input data change.
  always_comb begin
    hex_d = '0;
    for (int d = 0; d < DIGITS; d++) begin
      case (mode)
        MODE_BROWSE: hex_d[7*d +: 7] = seg_glyph(user_score[4*d +: 4]);
        MODE_PLAY:   hex_d[7*d +: 7] = seg_glyph(currentGameScore[4*d +: 4]);
        default:     hex_d[7*d +: 7] = C_DASH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      btn_q <= 1'b0;
      sel_q <= '0;
      hex_q <= {DIGITS{C_BLANK}};
    end else begin
      btn_q <= btn_d;
      sel_q <= sel_d;
      hex_q <= hex_d;
    end
  end

`ifdef SCORE_AUTO_CYCLE_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign hex_out  = hex_q;
  assign sel_user = sel_q;

endmodule
`default_nettype wire

// File: tb/tb_score_display_ctrl.sv
`default_nettype none
// Directed self-checking bench for score_display_ctrl (NUM_USERS=6, DIGITS=2).
module tb_score_display_ctrl;

  localparam int NU = 6;
  localparam int DG = 2;
  localparam int CT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ac_button;
  logic        access_granted;
  logic        scoreRst;
  logic [7:0]  currentGameScore;
  logic [47:0] score_bus;
  logic [13:0] hex_out;
  logic [2:0]  sel_user;

  int n_checks = 0;
  int n_errors = 0;
  int exp_sel;
  logic [7:0] users [NU];

  score_display_ctrl #(
    .NUM_USERS  (NU),
    .DIGITS     (DG),
    .CYCLE_TICKS(CT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .ac_button       (ac_button),
    .access_granted  (access_granted),
    .scoreRst        (scoreRst),
    .currentGameScore(currentGameScore),
    .score_bus       (score_bus),
    .hex_out         (hex_out),
    .sel_user        (sel_user)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [13:0] pair(input logic [7:0] v);
    return {glyph(v[7:4]), glyph(v[3:0])};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle to the falling edge for sampling and driving.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    users[0] = 8'h3A; users[1] = 8'h07; users[2] = 8'h11;
    users[3] = 8'hC5; users[4] = 8'h9F; users[5] = 8'hE8;
    score_bus = {users[5], users[4], users[3], users[2], users[1], users[0]};
    rst = 1'b0; ac_button = 1'b0; access_granted = 1'b1; scoreRst = 1'b1;
    currentGameScore = 8'h00;

    step(2);
    check("reset_hex", 32'(hex_out), 32'h3FFF);
    check("reset_sel", 32'(sel_user), 0);

    rst = 1'b1; access_granted = 1'b0;
    step();
    check("noaccess_hex", 32'(hex_out), {18'd0, 7'b0111111, 7'b0111111});
    check("noaccess_sel", 32'(sel_user), 0);

    access_granted = 1'b1; scoreRst = 1'b1;
    step();
    check("browse_u0_hex", 32'(hex_out), 32'(pair(8'h3A)));
    check("browse_u0_sel", 32'(sel_user), 0);

`ifdef SCORE_AUTO_CYCLE_EN
    // Counter began at 0 on the first BROWSE cycle above; ticks on its 4th cycle.
    step(2);
    check("auto_pre_tick_sel", 32'(sel_user), 0);
    step();
    check("auto_tick1_sel", 32'(sel_user), 1);
    step(3);
    check("auto_pre_tick2_sel", 32'(sel_user), 1);
    ac_button = 1'b1;
    step();
    check("auto_tick_and_btn_sel", 32'(sel_user), 2);
    ac_button = 1'b0;
    step(3);
    check("auto_restart_hold_sel", 32'(sel_user), 2);
    check("auto_restart_hex", 32'(hex_out), 32'(pair(users[2])));
    step();
    check("auto_restart_tick_sel", 32'(sel_user), 3);
`else
    ac_button = 1'b1;
    step();
    check("pulse1_sel", 32'(sel_user), 1);
    check("pulse1_hex_lag", 32'(hex_out), 32'(pair(8'h3A)));
    ac_button = 1'b0;
    step();
    check("pulse1_hex", 32'(hex_out), 32'(pair(8'h07)));

    exp_sel = 1;
    for (int p = 0; p < 6; p++) begin
      ac_button = 1'b1;
      step();
      exp_sel = (exp_sel + 1) % NU;
      check($sformatf("pulse_run%0d_sel", p), 32'(sel_user), 32'(exp_sel));
      ac_button = 1'b0;
      step();
      check($sformatf("pulse_run%0d_hex", p), 32'(hex_out), 32'(pair(users[exp_sel])));
    end

    ac_button = 1'b1;
    step(100);
    exp_sel = (exp_sel + 1) % NU;
    check("held_button_sel", 32'(sel_user), 32'(exp_sel));
    ac_button = 1'b0;
    step(20);
    check("idle_browse_sel", 32'(sel_user), 32'(exp_sel));

    // Reset while a button edge is pending, then edge on first free cycle.
    ac_button = 1'b1; rst = 1'b0;
    step();
    check("mid_reset_hex", 32'(hex_out), 32'h3FFF);
    check("mid_reset_sel", 32'(sel_user), 0);
    rst = 1'b1;
    step();
    check("post_reset_sel", 32'(sel_user), 1);
    check("post_reset_hex", 32'(hex_out), 32'(pair(8'h3A)));
    ac_button = 1'b0;
`endif

    scoreRst = 1'b0; currentGameScore = 8'h42;
    step();
    check("play_hex", 32'(hex_out), 32'(pair(8'h42)));
    check("play_sel", 32'(sel_user), 0);
    currentGameScore = 8'hBD;
    step();
    check("play_hex2", 32'(hex_out), 32'(pair(8'hBD)));

    ac_button = 1'b1;
    step();
    scoreRst = 1'b1;
    step();
    check("reenter_held_sel", 32'(sel_user), 0);
    check("reenter_hex", 32'(hex_out), 32'(pair(8'h3A)));

    access_granted = 1'b0;
    step();
    check("exit_hex", 32'(hex_out), {18'd0, 7'b0111111, 7'b0111111});
    check("exit_sel", 32'(sel_user), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/score_display_ctrl.md
SCORE_DISPLAY_CTRL -- requirements
Module: score_display_ctrl

Interface
REQ-001 The block SHALL take parameter NUM_USERS, default 6: number of stored user high scores, 2..16.
REQ-002 The block SHALL take parameter DIGITS, default 2: number of hex digits per score and number of 7-seg displays driven, 1..4.
REQ-003 The block SHALL take parameter CYCLE_TICKS, default 50000000: clock cycles per auto-advance period, >=2.
REQ-004 Port clk, input, 1: the single system clock; all logic is rising-edge.
REQ-005 Port rst, input, 1: reset, synchronous and active-low.
REQ-006 Port ac_button, input, 1: access button, active-high, already synchronised to clk.
REQ-007 Port access_granted, input, 1: high when a user is authenticated.
REQ-008 Port scoreRst, input, 1: high when the game has not started.
REQ-009 Port currentGameScore, input, 4*DIGITS: live game score, hex nibbles, LSN = rightmost display.
REQ-010 Port score_bus, input, NUM_USERS*4*DIGITS: flattened high scores; user k occupies bits [4*DIGITS*(k+1)-1 : 4*DIGITS*k].
REQ-011 Port hex_out, output, 7*DIGITS: registered active-low segments; display d occupies bits [7d+6:7d], bit 6 = segment g.
REQ-012 Port sel_user, output, clog2(NUM_USERS): registered index of the user whose score is shown.

Function
REQ-013 The mode SHALL be decoded each cycle: NOACCESS (access_granted=0), BROWSE (access_granted=1, scoreRst=1), PLAY (access_granted=1, scoreRst=0).
REQ-014 NOACCESS: hex_out SHALL drive dash (7'b0111111) on every display, sel_user SHALL be 0, and the tick counter SHALL be 0.
REQ-015 BROWSE: hex_out SHALL show score_bus slice sel_user, each nibble decoded to the 0-F active-low 7-seg glyph.
REQ-016 PLAY: hex_out SHALL show currentGameScore, and sel_user and the tick counter SHALL be held at 0.
REQ-017 A rising edge of ac_button (current=1, previous=0) in BROWSE SHALL advance sel_user by one; a held button SHALL advance it only once.
REQ-018 sel_user SHALL wrap from NUM_USERS-1 to 0; values >= NUM_USERS SHALL never occur.
REQ-019 hex_out SHALL be registered: the glyph for a new sel_user or new input data SHALL appear exactly one cycle after sel_user or the input changes.
REQ-020 On a mode transition, hex_out SHALL show the new mode's content on the cycle after the transition; BROWSE re-entry SHALL start at user 0.
REQ-021 The ac_button edge detector register SHALL update in all modes, so a button held while entering BROWSE SHALL not cause an advance.

Reset
REQ-022 While rst=0 at a clock edge, hex_out SHALL become all-ones (blank), sel_user 0, tick counter 0, and the button history register 0.
REQ-023 Reset SHALL override every other input, including mid-BROWSE and mid-advance; the first non-reset cycle SHALL decode the mode normally.

Configuration
REQ-024 Macro SCORE_AUTO_CYCLE_EN defined: in BROWSE a counter SHALL count clk cycles and, on reaching CYCLE_TICKS-1, SHALL advance sel_user (with wrap) and clear itself.
REQ-025 With SCORE_AUTO_CYCLE_EN defined, any advance (button or tick) SHALL clear the counter; a simultaneous button edge and tick SHALL advance by exactly one.
REQ-026 SCORE_AUTO_CYCLE_EN undefined: no counter SHALL be synthesised, and sel_user SHALL change only on a button edge, a mode exit, or reset.

Verification
REQ-027 Hold rst=0 for 2 cycles with access_granted=1 -> hex_out all ones and sel_user=0 while in reset.
REQ-028 Defaults, access_granted=0 -> hex_out = {7'b0111111, 7'b0111111}.
REQ-029 BROWSE with user0=8'h3A and user1=8'h07, one button pulse -> sel_user 0->1, and hex_out goes from glyphs "3","A" to "0","7" one cycle later.
REQ-030 BROWSE, 6 button pulses -> sel_user runs 1,2,3,4,5,0; button held 100 cycles -> exactly one advance.
REQ-031 PLAY with currentGameScore=8'h42 -> hex_out glyphs "4","2"; returning to BROWSE -> sel_user=0.
REQ-032 SCORE_AUTO_CYCLE_EN defined, CYCLE_TICKS=4 -> an advance every 4 cycles; a button edge on the tick cycle -> a single advance, and the counter restarts.
